uart_tx_frame: RTL and testbench

Serial transmitter that produces the 7-bit, even-parity UART frames consumed by the UART receiver on the same link. It accepts parallel words over a valid/ready handshake, buffers one pending word behind the word on the wire, and serializes each word LSB-last (MSB first) on `tx`. It is the upstream stage of the receive path: its `tx` drives the receiver's `rx` in loopback and board-level tests.

---
 rtl/uart_tx_frame_if.sv | 9 +
 rtl/uart_tx_frame.sv | 143 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake into the 7-bit UART frame transmitter.
interface uart_tx_frame_if;
  logic [6:0] data_in;
  logic       valid;
  logic       ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_tx_frame.sv
// 7-bit even-parity UART frame transmitter, MSB first, one-word holding buffer.
// Frame: start(0), data[6:0] MSB first, parity (^data), stop(1).
// Optional macro UART_TX_BAUD_DIV_EN: compiles in a 16-bit bit-period counter so
// each bit lasts CLKS_PER_BIT cycles; otherwise each bit lasts one sys_clk cycle.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  uart_tx_frame_if.slave  bus,
  output logic            tx,
  output logic            busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e     r_state;
  logic [6:0] r_shift;
  logic       r_parity;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_hold;
  logic       r_hold_full;
  logic       r_tx;
  logic       r_busy;

  logic       w_tick;
  logic       w_accept;
  logic       w_stop_end;
  logic       w_to_hold;
  logic [6:0] w_load_word;

`ifdef UART_TX_BAUD_DIV_EN
  logic [15:0] r_baud;

  assign w_tick = (r_baud == 16'(CLKS_PER_BIT - 1));

  // Bit-period counter: idle and every bit boundary return it to 0, so each load restarts it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
    end else if (r_state == StIdle || w_tick) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + 16'd1;
    end
  end
`else
  logic w_unused_cpb;
  assign w_unused_cpb = ^CLKS_PER_BIT;
  assign w_tick       = 1'b1;
`endif

  assign bus.ready  = !r_hold_full;
  assign w_accept   = bus.valid && !r_hold_full;
  assign w_stop_end = (r_state == StStop) && w_tick;
  // A word accepted while a frame is running (and not at its last edge) waits in holding.
  assign w_to_hold  = (r_state != StIdle) && !w_stop_end;
  // The holding word takes priority over the input word at the end of STOP.
  assign w_load_word = (w_stop_end && r_hold_full) ? r_hold : bus.data_in;

  assign tx   = r_tx;
  assign busy = r_busy;

  // Frame sequencer with registered tx/busy and the holding-slot bookkeeping.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_bit_cnt   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_shift  <= w_load_word;
            r_parity <= ^w_load_word;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= StStart;
          end
        end
        StStart: begin
          if (w_tick) begin
            r_tx      <= r_shift[6];
            r_shift   <= {r_shift[5:0], 1'b0};
            r_bit_cnt <= '0;
            r_state   <= StData;
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_bit_cnt == 3'd6) begin
              r_tx    <= r_parity;
              r_state <= StParity;
            end else begin
              r_tx      <= r_shift[6];
              r_shift   <= {r_shift[5:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        StParity: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= StStop;
          end
        end
        StStop: begin
          if (w_tick) begin
            if (r_hold_full || w_accept) begin
              r_shift  <= w_load_word;
              r_parity <= ^w_load_word;
              r_tx     <= 1'b0;
              r_state  <= StStart;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end
            if (r_hold_full) begin
              r_hold_full <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_accept && w_to_hold) begin
        r_hold      <= bus.data_in;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frame-level queue model plus literal frame sequences.
module tb_uart_tx_frame;

`ifdef UART_TX_BAUD_DIV_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic clk;
  logic rst_n;
  logic tx;
  logic busy;

  uart_tx_frame_if bus_if ();

  uart_tx_frame #(.CLKS_PER_BIT(4)) dut (
    .sys_clk(clk),
    .rst_n  (rst_n),
    .bus    (bus_if),
    .tx     (tx),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: per-cycle line values still to be shown, plus one pending word.
  bit         m_q[$];
  logic [6:0] m_pend;
  bit         m_pend_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [6:0] w);
    logic [9:0] f;
    f = {1'b0, w, ^w, 1'b1};
    for (int b = 9; b >= 0; b--) begin
      for (int k = 0; k < P; k++) m_q.push_back(f[b]);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pend_full = 1'b0;
    m_pend      = '0;
  endfunction

  function automatic void model_step(input logic v, input logic [6:0] d);
    bit acc;
    acc = v && !m_pend_full;
    if (m_q.size() != 0) void'(m_q.pop_front());
    if (m_q.size() == 0) begin
      if (m_pend_full) begin
        push_frame(m_pend);
        m_pend_full = 1'b0;
      end else if (acc) begin
        push_frame(d);
      end
    end else if (acc) begin
      m_pend      = d;
      m_pend_full = 1'b1;
    end
  endfunction

  task automatic compare_model();
    logic exp_tx;
    exp_tx = (m_q.size() != 0) ? m_q[0] : 1'b1;
    chk("model_tx", 32'(tx), 32'(exp_tx));
    chk("model_busy", 32'(busy), 32'(m_q.size() != 0));
    chk("model_ready", 32'(bus_if.ready), 32'(!m_pend_full));
  endtask

  // Called at a negedge: drive, clock the DUT and model, then compare.
  task automatic cycle(input logic v, input logic [6:0] d);
    bus_if.valid   = v;
    bus_if.data_in = d;
    @(posedge clk);
    model_step(v, d);
    @(negedge clk);
    compare_model();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus_if.ready), 32'd1);
    model_reset();
    bus_if.valid = 1'b0;
    @(negedge clk);
    compare_model();
    rst_n = 1'b1;
  endtask

  // Single frame against a literal sequence, then reassemble the word MSB first.
  task automatic directed(input logic [6:0] w, input logic [9:0] seq, input string name);
    logic [9:0] got;
    logic [6:0] word;
    got = '0;
    for (int i = 0; i < 10 * P; i++) begin
      if (i == 0) cycle(1'b1, w);
      else cycle(1'b0, 7'h00);
      chk({name, "_seq"}, 32'(tx), 32'(seq[9 - i / P]));
      if (i % P == 0) got[9 - i / P] = tx;
    end
    word = got[8:2];
    chk({name, "_word"}, 32'(word), 32'(w));
    cycle(1'b0, 7'h00);
    chk({name, "_idle_tx"}, 32'(tx), 32'd1);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [19:0] b2b;
    rst_n          = 1'b0;
    bus_if.valid   = 1'b0;
    bus_if.data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(bus_if.ready), 32'd1);
    rst_n = 1'b1;
    cycle(1'b0, 7'h00);

    directed(7'h55, 10'b0101010101, "f55");
    directed(7'h01, 10'b0000000111, "f01");
    directed(7'h33, 10'b0011001101, "f33");
    directed(7'h40, 10'b0100000011, "f40");

    // Back-to-back: second word sits in holding, frames abut.
    b2b = 20'b01111111110000000001;
    for (int i = 0; i < 20 * P; i++) begin
      if (i == 0) cycle(1'b1, 7'h7F);
      else if (i == 1) begin
        cycle(1'b1, 7'h00);
        chk("b2b_ready_low", 32'(bus_if.ready), 32'd0);
      end else cycle(1'b0, 7'h00);
      chk("b2b_seq", 32'(tx), 32'(b2b[19 - i / P]));
      chk("b2b_busy", 32'(busy), 32'd1);
    end
    cycle(1'b0, 7'h00);
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // Reset during DATA bit 3 of 7'h2A with a word pending.
    cycle(1'b1, 7'h2A);
    cycle(1'b1, 7'h15);
    for (int i = 0; i < 3 * P; i++) cycle(1'b0, 7'h00);
    chk("mid_pending", 32'(bus_if.ready), 32'd0);
    async_reset();
    for (int i = 0; i < 12 * P; i++) begin
      cycle(1'b0, 7'h2A);
      chk("post_rst_tx", 32'(tx), 32'd1);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000 * P; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      else cycle(($urandom_range(0, 3) != 0), 7'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
